multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I subset core. It sequences fetch, decode, execute, memory and write-back over the shared ALU, register file and unified memory port.
- It takes the decoded fields (opcode, funct3, funct7[5]) and the ALU Zero flag.
- It produces per-cycle enables, mux selects and the 4-bit AluControl consumed by the ALU.
- It handshakes with memory via Mem_Ready and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for Mem_Ready in any memory state before trapping.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Opcode  input  7  Instruction[6:0] from IR.
- Funct3  input  3  Instruction[14:12].
- Funct7_5  input  1  Instruction[30].
- Zero  input  1  ALU result == 0.
- Mem_Ready  input  1  memory completes the current access this cycle.
- PC_Write  output  1  load PC.
- PC_Src  output  1  0 = PC+4, 1 = branch target.
- IR_Write  output  1  latch fetched word into IR.
- Mem_Read  output  1  memory read request.
- Mem_Write  output  1  memory write request.
- I_or_D  output  1  0 = address from PC, 1 = address from ALUOut.
- Reg_Write  output  1  register-file write enable.
- Mem_To_Reg  output  1  0 = ALUOut, 1 = MDR as write-back data.
- ALU_Src_A  output  1  0 = PC, 1 = rs1.
- ALU_Src_B  output  2  00 = rs2, 01 = const 4, 10 = immediate.
- AluControl  output  4  ALU operation code.
- State  output  4  current state, for debug.
- Illegal  output  1  sticky; set on trap.
- Retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (synchronous, active-high):
  - State = FETCH, Retired = 0, Illegal = 0, wait counter = 0.
  - All enables/requests are forced to 0 in any cycle where Reset is high, regardless of state.
  - Reset mid-access abandons the access with no write issued.
- Outputs are a combinational decode of the registered state. Exception: PC_Write in BRANCH depends on Zero/Funct3.
- State encoding lives in the package: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=15.
- FETCH:
  - Mem_Read=1, I_or_D=0, ALU_Src_A=0, ALU_Src_B=01, AluControl=ADD.
  - On Mem_Ready: IR_Write=1, PC_Write=1, PC_Src=0, go DECODE. Otherwise stay.
- DECODE: AluControl=ADD, ALU_Src_A=0, ALU_Src_B=10 (precompute branch target). Next state by Opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - anything else -> TRAP
- EXEC_R: ALU_Src_A=1, ALU_Src_B=00, AluControl from Funct3/Funct7_5; go WB_ALU.
- EXEC_I: as EXEC_R but ALU_Src_B=10. Funct7_5 is honoured only for Funct3=101 (SRAI), otherwise ignored. Go WB_ALU.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ADD. Opcode 0000011 -> MEM_RD, else MEM_WR.
- MEM_RD: Mem_Read=1, I_or_D=1; wait for Mem_Ready, then WB_MEM.
- MEM_WR: Mem_Write=1, I_or_D=1; wait for Mem_Ready, then retire and go FETCH.
- WB_ALU: Reg_Write=1, Mem_To_Reg=0; retire, go FETCH.
- WB_MEM: Reg_Write=1, Mem_To_Reg=1; retire, go FETCH.
- BRANCH:
  - ALU_Src_A=1, ALU_Src_B=00, SUB, PC_Src=1.
  - PC_Write = Zero when Funct3=000, ~Zero when Funct3=001.
  - Any other Funct3 -> TRAP with PC_Write=0.
  - Otherwise retire, go FETCH.
- Retire means Retired increments by 1 on the exiting edge and wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states without Mem_Ready.
  - When the counter reaches MEM_TIMEOUT with Mem_Ready still low -> TRAP.
  - Mem_Ready in the same cycle the counter reaches the limit wins: normal transition, no trap.
- TRAP: all enables 0, Illegal=1; absorbing until Reset.
- AluControl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- Funct3 map: 000 ADD/SUB (SUB only R-type with Funct7_5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by Funct7_5, 110 OR, 111 AND.

Decomposition:
- Package control_pkg holds:
  - state encoding constants;
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - AluControl codes;
  - ALU_Src_B select codes.
- One sub-module, alu_decoder: combinational map of (Funct3, Funct7_5, is_rtype) to AluControl, reused by EXEC_R and EXEC_I.

Test Plan:
- Reset held 2 cycles, then R-type ADD (Opcode=0110011, F3=000, F7_5=0), Mem_Ready=1 in fetch:
  - State goes 0,1,2,7,0.
  - Reg_Write=1 only in WB_ALU, AluControl=0000 in EXEC_R.
  - Retired=1.
- R-type SUB (F7_5=1) -> AluControl=0001. I-type ADDI with F7_5=1 -> AluControl=0000 (bit ignored).
- Load with Mem_Ready delayed 3 cycles in MEM_RD:
  - Mem_Read held high 4 cycles, then WB_MEM with Mem_To_Reg=1.
  - Total 8 cycles including 1-cycle fetch.
- BEQ with Zero=1 -> PC_Write=1, PC_Src=1 in BRANCH. BNE with Zero=1 -> PC_Write=0. Both increment Retired.
- Opcode 1111111 -> TRAP (State=15, Illegal=1, no enables). Stays until Reset, after which State=0, Illegal=0.
- Mem_Ready never asserted in FETCH with MEM_TIMEOUT=16 -> TRAP after exactly 16 waiting cycles.
- Reset asserted mid MEM_WR -> Mem_Write=0 that same cycle, State=0 next cycle.

Source files
------------

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - state, opcode, ALU and operand-select encodings for multicycle_control
package control_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WR   = 4'd6,
      WB_ALU   = 4'd7,
      WB_MEM   = 4'd8,
      BRANCH   = 4'd9,
      TRAP     = 4'd15
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // States that own the memory port and are therefore bounded by the timeout.
   function automatic logic is_wait_state(input state_t s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - decoded-field inputs and control outputs of the multicycle core
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       Opcode;
   logic [2:0]       Funct3;
   logic             Funct7_5;
   logic             Zero;
   logic             Mem_Ready;
   logic             PC_Write;
   logic             PC_Src;
   logic             IR_Write;
   logic             Mem_Read;
   logic             Mem_Write;
   logic             I_or_D;
   logic             Reg_Write;
   logic             Mem_To_Reg;
   logic             ALU_Src_A;
   logic [1:0]       ALU_Src_B;
   logic [3:0]       AluControl;
   logic [3:0]       State;
   logic             Illegal;
   logic [CNT_W-1:0] Retired;

   modport master (
      input  Opcode, Funct3, Funct7_5, Zero, Mem_Ready,
      output PC_Write, PC_Src, IR_Write, Mem_Read, Mem_Write, I_or_D, Reg_Write,
             Mem_To_Reg, ALU_Src_A, ALU_Src_B, AluControl, State, Illegal, Retired
   );

   modport slave (
      output Opcode, Funct3, Funct7_5, Zero, Mem_Ready,
      input  PC_Write, PC_Src, IR_Write, Mem_Read, Mem_Write, I_or_D, Reg_Write,
             Mem_To_Reg, ALU_Src_A, ALU_Src_B, AluControl, State, Illegal, Retired
   );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps Funct3/Funct7_5 to AluControl for register and immediate ops
module alu_decoder
   import control_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output alu_op_t    alu_control
);

   // Funct7_5 selects SUB only for register ops; immediate ops carry imm bits there.
   always_comb begin
      alu_control = ALU_ADD;
      case (funct3)
         3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_control = ALU_SLL;
         3'b010:  alu_control = ALU_SLT;
         3'b011:  alu_control = ALU_SLTU;
         3'b100:  alu_control = ALU_XOR;
         3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_control = ALU_OR;
         3'b111:  alu_control = ALU_AND;
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main sequencing FSM of the multicycle RV32I subset core
module multicycle_control
   import control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                 Clock,
   input  logic                 Reset,
   multicycle_control_if.master bus
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               illegal_q, illegal_d;

   logic               retire;
   logic               waiting;
   logic               timed_out;
   alu_op_t            exec_alu;
   alu_op_t            alu_ctl;
   logic               pc_write, pc_src, ir_write, mem_read, mem_write;
   logic               i_or_d, reg_write, mem_to_reg, src_a;
   logic [1:0]         src_b;

   alu_decoder u_alu_decoder (
      .funct3      (bus.Funct3),
      .funct7_5    (bus.Funct7_5),
      .is_rtype    (state_q == EXEC_R),
      .alu_control (exec_alu)
   );

   // A ready arriving in the final allowed cycle still completes the access.
   assign waiting   = is_wait_state(state_q) && !bus.Mem_Ready;
   assign timed_out = waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      src_a      = 1'b0;
      src_b      = SRCB_RS2;
      alu_ctl    = ALU_ADD;
      case (state_q)
         FETCH: begin
            mem_read = 1'b1;
            src_b    = SRCB_FOUR;
            if (bus.Mem_Ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end else if (timed_out) begin
               state_d = TRAP;
            end
         end
         DECODE: begin
            src_b = SRCB_IMM;
            case (bus.Opcode)
               OP_R:              state_d = EXEC_R;
               OP_I:              state_d = EXEC_I;
               OP_LOAD, OP_STORE: state_d = MEM_ADDR;
               OP_BRANCH:         state_d = BRANCH;
               default:           state_d = TRAP;
            endcase
         end
         EXEC_R: begin
            src_a   = 1'b1;
            alu_ctl = exec_alu;
            state_d = WB_ALU;
         end
         EXEC_I: begin
            src_a   = 1'b1;
            src_b   = SRCB_IMM;
            alu_ctl = exec_alu;
            state_d = WB_ALU;
         end
         MEM_ADDR: begin
            src_a   = 1'b1;
            src_b   = SRCB_IMM;
            state_d = (bus.Opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (bus.Mem_Ready)  state_d = WB_MEM;
            else if (timed_out) state_d = TRAP;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (bus.Mem_Ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end else if (timed_out) begin
               state_d = TRAP;
            end
         end
         WB_ALU: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = FETCH;
         end
         BRANCH: begin
            src_a   = 1'b1;
            alu_ctl = ALU_SUB;
            pc_src  = 1'b1;
            case (bus.Funct3)
               3'b000: begin
                  pc_write = bus.Zero;
                  retire   = 1'b1;
                  state_d  = FETCH;
               end
               3'b001: begin
                  pc_write = ~bus.Zero;
                  retire   = 1'b1;
                  state_d  = FETCH;
               end
               default: state_d = TRAP;
            endcase
         end
         TRAP:    state_d = TRAP;
         default: state_d = TRAP;
      endcase
   end

   always_comb begin
      wait_d    = waiting ? wait_q + 1'b1 : '0;
      retired_d = retire ? retired_q + 1'b1 : retired_q;
      illegal_d = illegal_q | (state_d == TRAP);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   // Requests and enables are suppressed while Reset is high so an access in flight is dropped.
   assign bus.PC_Write   = pc_write  & ~Reset;
   assign bus.IR_Write   = ir_write  & ~Reset;
   assign bus.Mem_Read   = mem_read  & ~Reset;
   assign bus.Mem_Write  = mem_write & ~Reset;
   assign bus.Reg_Write  = reg_write & ~Reset;
   assign bus.PC_Src     = pc_src;
   assign bus.I_or_D     = i_or_d;
   assign bus.Mem_To_Reg = mem_to_reg;
   assign bus.ALU_Src_A  = src_a;
   assign bus.ALU_Src_B  = src_b;
   assign bus.AluControl = alu_ctl;
   assign bus.State      = state_q;
   assign bus.Illegal    = illegal_q;
   assign bus.Retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

   logic Clock = 1'b0;
   logic Reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   multicycle_control_if #(.CNT_W(32)) bus ();

   multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #2;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; bus.Mem_Ready = 1'b1; bus.Opcode = 7'b0110011;
      bus.Funct3 = 3'b000; bus.Funct7_5 = 1'b0; bus.Zero = 1'b0;
      tick(); tick();
      n_checks++; if (bus.State !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.State); end
      n_checks++; if (bus.Retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d exp 0", bus.Retired); end
      n_checks++; if (bus.Illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", bus.Illegal); end
      n_checks++; if ({bus.Mem_Read, bus.IR_Write, bus.PC_Write} !== 3'b000) begin n_fail++; $display("FAIL reset_enables got %b exp 000", {bus.Mem_Read, bus.IR_Write, bus.PC_Write}); end
      Reset = 1'b0; #1;
      n_checks++; if ({bus.Mem_Read, bus.IR_Write, bus.PC_Write, bus.ALU_Src_B} !== 5'b11101) begin n_fail++; $display("FAIL fetch_outputs got %b exp 11101", {bus.Mem_Read, bus.IR_Write, bus.PC_Write, bus.ALU_Src_B}); end
   endtask

   task automatic test_r_add();
      logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd2, 4'd7};
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (bus.State !== exp_st[i]) begin n_fail++; $display("FAIL radd_state[%0d] got %0d exp %0d", i, bus.State, exp_st[i]); end
         n_checks++; if (bus.Reg_Write !== (exp_st[i] == 4'd7)) begin n_fail++; $display("FAIL radd_regwrite[%0d] got %b", i, bus.Reg_Write); end
         if (bus.State == 4'd2) begin
            n_checks++; if (bus.AluControl !== 4'b0000) begin n_fail++; $display("FAIL radd_alu got %b exp 0000", bus.AluControl); end
         end
         tick(); #1;
      end
      n_checks++; if (bus.State !== 4'd0) begin n_fail++; $display("FAIL radd_end_state got %0d exp 0", bus.State); end
      n_checks++; if (bus.Retired !== 32'd1) begin n_fail++; $display("FAIL radd_retired got %0d exp 1", bus.Retired); end
   endtask

   task automatic test_r_sub();
      bus.Funct7_5 = 1'b1;
      tick(); tick(); #1;
      n_checks++; if ({bus.State, bus.AluControl} !== {4'd2, 4'b0001}) begin n_fail++; $display("FAIL rsub_alu got st %0d alu %b exp st 2 alu 0001", bus.State, bus.AluControl); end
      tick(); tick(); #1;
      n_checks++; if (bus.Retired !== 32'd2) begin n_fail++; $display("FAIL rsub_retired got %0d exp 2", bus.Retired); end
   endtask

   task automatic test_addi_f7();
      bus.Opcode = 7'b0010011; bus.Funct3 = 3'b000; bus.Funct7_5 = 1'b1;
      tick(); tick(); #1;
      n_checks++; if ({bus.State, bus.AluControl, bus.ALU_Src_B} !== {4'd3, 4'b0000, 2'b10}) begin n_fail++; $display("FAIL addi_alu got st %0d alu %b srcb %b exp 3 0000 10", bus.State, bus.AluControl, bus.ALU_Src_B); end
      bus.Funct3 = 3'b101; #1;
      n_checks++; if (bus.AluControl !== 4'b0111) begin n_fail++; $display("FAIL srai_alu got %b exp 0111", bus.AluControl); end
      bus.Funct3 = 3'b000;
      tick(); tick(); #1;
      n_checks++; if (bus.Retired !== 32'd3) begin n_fail++; $display("FAIL addi_retired got %0d exp 3", bus.Retired); end
   endtask

   task automatic test_load_delay();
      int cyc = 0;
      int rd  = 0;
      bus.Opcode = 7'b0000011; bus.Funct3 = 3'b010; bus.Funct7_5 = 1'b0;
      do begin
         cyc++;
         if (bus.State == 4'd5) begin rd++; bus.Mem_Ready = (rd == 4); end
         else bus.Mem_Ready = 1'b1;
         #1;
         if (bus.State == 4'd5) begin
            n_checks++; if ({bus.Mem_Read, bus.I_or_D} !== 2'b11) begin n_fail++; $display("FAIL load_memrd got %b exp 11", {bus.Mem_Read, bus.I_or_D}); end
         end
         if (bus.State == 4'd8) begin
            n_checks++; if ({bus.Reg_Write, bus.Mem_To_Reg} !== 2'b11) begin n_fail++; $display("FAIL load_wbmem got %b exp 11", {bus.Reg_Write, bus.Mem_To_Reg}); end
         end
         tick();
      end while (bus.State != 4'd0 && cyc < 20);
      bus.Mem_Ready = 1'b1; #1;
      n_checks++; if (rd !== 4) begin n_fail++; $display("FAIL load_rd_cycles got %0d exp 4", rd); end
      n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL load_total_cycles got %0d exp 8", cyc); end
      n_checks++; if (bus.Retired !== 32'd4) begin n_fail++; $display("FAIL load_retired got %0d exp 4", bus.Retired); end
   endtask

   task automatic test_branch();
      bus.Opcode = 7'b1100011; bus.Funct3 = 3'b000; bus.Zero = 1'b1;
      tick(); tick(); #1;
      n_checks++; if ({bus.State, bus.PC_Write, bus.PC_Src, bus.AluControl} !== {4'd9, 1'b1, 1'b1, 4'b0001}) begin n_fail++; $display("FAIL beq_taken got st %0d pcw %b pcs %b alu %b", bus.State, bus.PC_Write, bus.PC_Src, bus.AluControl); end
      tick(); #1;
      n_checks++; if (bus.Retired !== 32'd5) begin n_fail++; $display("FAIL beq_retired got %0d exp 5", bus.Retired); end
      bus.Funct3 = 3'b001;
      tick(); tick(); #1;
      n_checks++; if ({bus.State, bus.PC_Write} !== {4'd9, 1'b0}) begin n_fail++; $display("FAIL bne_nottaken got st %0d pcw %b exp 9 0", bus.State, bus.PC_Write); end
      tick(); #1;
      n_checks++; if ({bus.State, bus.Retired} !== {4'd0, 32'd6}) begin n_fail++; $display("FAIL bne_retired got st %0d ret %0d exp 0 6", bus.State, bus.Retired); end
   endtask

   task automatic test_trap_opcode();
      bus.Opcode = 7'b1111111; bus.Funct3 = 3'b000; bus.Zero = 1'b0;
      tick(); tick(); #1;
      n_checks++; if ({bus.State, bus.Illegal} !== {4'd15, 1'b1}) begin n_fail++; $display("FAIL trap_entry got st %0d ill %b exp 15 1", bus.State, bus.Illegal); end
      n_checks++; if ({bus.Mem_Read, bus.Mem_Write, bus.PC_Write, bus.IR_Write, bus.Reg_Write} !== 5'b0) begin n_fail++; $display("FAIL trap_enables got %b exp 00000", {bus.Mem_Read, bus.Mem_Write, bus.PC_Write, bus.IR_Write, bus.Reg_Write}); end
      repeat (3) tick();
      n_checks++; if (bus.State !== 4'd15) begin n_fail++; $display("FAIL trap_sticky got %0d exp 15", bus.State); end
      Reset = 1'b1; tick(); Reset = 1'b0; #1;
      n_checks++; if ({bus.State, bus.Illegal, bus.Retired} !== {4'd0, 1'b0, 32'd0}) begin n_fail++; $display("FAIL trap_release got st %0d ill %b ret %0d", bus.State, bus.Illegal, bus.Retired); end
   endtask

   task automatic test_fetch_timeout();
      int n = 0;
      bus.Opcode = 7'b0110011;
      do_reset();
      bus.Mem_Ready = 1'b0;
      while (bus.State == 4'd0 && n < 40) begin n++; tick(); end
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL timeout_cycles got %0d exp 16", n); end
      n_checks++; if ({bus.State, bus.Illegal} !== {4'd15, 1'b1}) begin n_fail++; $display("FAIL timeout_trap got st %0d ill %b exp 15 1", bus.State, bus.Illegal); end
   endtask

   task automatic test_ready_at_limit();
      do_reset();
      bus.Mem_Ready = 1'b0;
      repeat (15) tick();
      bus.Mem_Ready = 1'b1; #1;
      n_checks++; if ({bus.State, bus.IR_Write} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL limit_fetch got st %0d irw %b exp 0 1", bus.State, bus.IR_Write); end
      tick();
      n_checks++; if (bus.State !== 4'd1) begin n_fail++; $display("FAIL limit_decode got %0d exp 1", bus.State); end
   endtask

   task automatic test_reset_mid_write();
      bus.Opcode = 7'b0100011; bus.Mem_Ready = 1'b1;
      do_reset();
      tick(); bus.Mem_Ready = 1'b0; tick(); tick(); #1;
      n_checks++; if ({bus.State, bus.Mem_Write, bus.I_or_D} !== {4'd6, 1'b1, 1'b1}) begin n_fail++; $display("FAIL store_memwr got st %0d mw %b iod %b exp 6 1 1", bus.State, bus.Mem_Write, bus.I_or_D); end
      Reset = 1'b1; #1;
      n_checks++; if (bus.Mem_Write !== 1'b0) begin n_fail++; $display("FAIL reset_kills_write got %b exp 0", bus.Mem_Write); end
      tick(); Reset = 1'b0; #1;
      n_checks++; if ({bus.State, bus.Retired} !== {4'd0, 32'd0}) begin n_fail++; $display("FAIL reset_after_write got st %0d ret %0d exp 0 0", bus.State, bus.Retired); end
   endtask

   initial begin
      test_reset();
      test_r_add();
      test_r_sub();
      test_addi_f7();
      test_load_delay();
      test_branch();
      test_trap_opcode();
      test_fetch_timeout();
      test_ready_at_limit();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
